// File: rtl/cosim_pkg.sv
// Shared event types for the Spike co-simulation commit serializer.
// Payload fields are held at the widest supported XLEN.
package cosim_pkg;

    localparam int MAX_HARTS = 8;
    localparam int EV_XLEN   = 64;

    typedef enum logic {
        COMMIT = 1'b0,
        TRAP   = 1'b1
    } cosim_kind_e;

    typedef struct packed {
        logic [2:0]         hartid;
        cosim_kind_e        kind;
        logic [EV_XLEN-1:0] pc;
        logic [31:0]        insn;
        logic               wen;
        logic [4:0]         waddr;
        logic [EV_XLEN-1:0] wdata;
    } cosim_event_t;

endpackage

// File: rtl/cosim_hart_fifo.sv
// Per-hart event FIFO: compacting multi-push, single pop.
// A group is written whole or not at all, against pre-pop occupancy.
module cosim_hart_fifo
    import cosim_pkg::*;
#(
    parameter int SLOTS = 3,
    parameter int DEPTH = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [SLOTS-1:0] push_valid,
    input  cosim_event_t push_data [SLOTS],
    input  logic         pop,
    output cosim_event_t head,
    output logic         empty,
    output logic         nonempty_next,
    output logic         accept,
    output logic         drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    cosim_event_t mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW-1:0] slot_ptr [SLOTS];
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [CW-1:0] n;
    logic [CW-1:0] space;
    logic          do_pop;

    // Older slots land first; each valid slot takes the next free entry.
    always_comb begin
        n = '0;
        for (int s = 0; s < SLOTS; s++) begin
            slot_ptr[s] = wptr + AW'(n);
            if (push_valid[s]) n = n + 1'b1;
        end
    end

    assign space         = CW'(DEPTH) - count;
    assign accept        = n <= space;
    assign drop          = !accept;
    assign empty         = count == '0;
    assign do_pop        = pop && !empty;
    assign head          = mem[rptr];
    assign count_next    = count + (accept ? n : '0) - CW'(do_pop);
    assign nonempty_next = count_next != '0;

    always_ff @(posedge clock) begin
        if (!reset && accept) begin
            for (int s = 0; s < SLOTS; s++) begin
                if (push_valid[s]) mem[slot_ptr[s]] <= push_data[s];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (accept) wptr <= wptr + AW'(n);
            if (do_pop) rptr <= rptr + 1'b1;
            count <= count_next;
        end
    end

endmodule

// File: rtl/cosim_commit_serializer.sv
// Serializes per-hart commits and traps into one ordered event stream,
// with sticky overflow flags and a retirement hang watchdog.
module cosim_commit_serializer
    import cosim_pkg::*;
#(
    parameter int HARTS   = 1,
    parameter int COMMITS = 2,
    parameter int DEPTH   = 16,
    parameter int XLEN    = 64,
    parameter int TIMEOUT = 100000
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [HARTS*COMMITS-1:0]      commit_valid,
    input  logic [HARTS*COMMITS*XLEN-1:0] commit_pc,
    input  logic [HARTS*COMMITS*32-1:0]   commit_insn,
    input  logic [HARTS*COMMITS-1:0]      commit_wen,
    input  logic [HARTS*COMMITS*5-1:0]    commit_waddr,
    input  logic [HARTS*COMMITS*XLEN-1:0] commit_wdata,
    input  logic [HARTS-1:0]              trap_valid,
    input  logic [HARTS*XLEN-1:0]         trap_cause,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [2:0]                  out_hartid,
    output logic                        out_kind,
    output logic [XLEN-1:0]             out_pc,
    output logic [31:0]                 out_insn,
    output logic                        out_wen,
    output logic [4:0]                  out_waddr,
    output logic [XLEN-1:0]             out_wdata,
    output logic [HARTS-1:0]            overflow,
    output logic                        hang
);

    localparam int SLOTS = COMMITS + 1;
    localparam int WW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    cosim_event_t head     [HARTS];
    cosim_event_t head_all [MAX_HARTS];
    cosim_event_t cur;

    logic [HARTS-1:0]     empty;
    logic [HARTS-1:0]     nonempty_next;
    logic [HARTS-1:0]     accept;
    logic [HARTS-1:0]     drop;
    logic [HARTS-1:0]     pop;
    logic [HARTS-1:0]     has_commit;
    logic [MAX_HARTS-1:0] ne_cur;
    logic [MAX_HARTS-1:0] ne_next;
    logic [2:0]           sel;
    logic [2:0]           sel_next;
    logic [2:0]           rr;
    logic [2:0]           rr_next;
    logic [3:0]           cand;
    logic                 fire;
    logic                 commit_acc;
    logic                 armed;
    logic [WW-1:0]        wd_cnt;

    for (genvar h = 0; h < HARTS; h++) begin : g_hart
        logic [SLOTS-1:0] pv;
        cosim_event_t     pd [SLOTS];

        always_comb begin
            for (int s = 0; s < COMMITS; s++) begin
                pd[s]               = '0;
                pd[s].hartid        = 3'(h);
                pd[s].kind          = COMMIT;
                pd[s].pc[XLEN-1:0]  = commit_pc[(h*COMMITS+s)*XLEN +: XLEN];
                pd[s].insn          = commit_insn[(h*COMMITS+s)*32 +: 32];
                pd[s].wen           = commit_wen[h*COMMITS+s];
                pd[s].waddr         = commit_waddr[(h*COMMITS+s)*5 +: 5];
                pd[s].wdata[XLEN-1:0] = commit_wdata[(h*COMMITS+s)*XLEN +: XLEN];
            end
            pd[COMMITS]        = '0;
            pd[COMMITS].hartid = 3'(h);
            pd[COMMITS].kind   = TRAP;
            pd[COMMITS].wdata[XLEN-1:0] = trap_cause[h*XLEN +: XLEN];
        end

        assign pv            = {trap_valid[h], commit_valid[h*COMMITS +: COMMITS]};
        assign has_commit[h] = |commit_valid[h*COMMITS +: COMMITS];
        assign pop[h]        = fire && (sel == 3'(h));

        cosim_hart_fifo #(
            .SLOTS (SLOTS),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clock         (clock),
            .reset         (reset),
            .push_valid    (pv),
            .push_data     (pd),
            .pop           (pop[h]),
            .head          (head[h]),
            .empty         (empty[h]),
            .nonempty_next (nonempty_next[h]),
            .accept        (accept[h]),
            .drop          (drop[h])
        );
    end

    always_comb begin
        for (int h = 0; h < MAX_HARTS; h++) head_all[h] = '0;
        for (int h = 0; h < HARTS; h++) head_all[h] = head[h];
    end

    assign ne_cur  = MAX_HARTS'(~empty);
    assign ne_next = MAX_HARTS'(nonempty_next);
    assign cur       = head_all[sel];
    assign out_valid = ne_cur[sel];
    assign fire      = out_valid && out_ready;

    // Selection is decided at the edge from next-cycle occupancy, so the
    // output mux runs straight off registers and a stalled event holds.
    always_comb begin
        rr_next  = rr;
        sel_next = sel;
        cand     = '0;
        if (fire) rr_next = (sel == 3'(HARTS-1)) ? 3'd0 : sel + 3'd1;
        if (!(out_valid && !out_ready)) begin
            sel_next = rr_next;
            for (int k = HARTS-1; k >= 0; k--) begin
                cand = {1'b0, rr_next} + 4'(k);
                if (cand >= 4'(HARTS)) cand = cand - 4'(HARTS);
                if (ne_next[cand[2:0]]) sel_next = cand[2:0];
            end
        end
    end

    assign out_hartid = out_valid ? cur.hartid : '0;
    assign out_kind   = out_valid && (cur.kind == TRAP);
    assign out_pc     = out_valid ? cur.pc[XLEN-1:0] : '0;
    assign out_insn   = out_valid ? cur.insn : '0;
    assign out_wen    = out_valid && cur.wen;
    assign out_waddr  = out_valid ? cur.waddr : '0;
    assign out_wdata  = out_valid ? cur.wdata[XLEN-1:0] : '0;

    assign commit_acc = |(has_commit & accept);

    always_ff @(posedge clock) begin
        if (reset) begin
            sel      <= '0;
            rr       <= '0;
            overflow <= '0;
            hang     <= 1'b0;
            armed    <= 1'b0;
            wd_cnt   <= '0;
        end else begin
            sel      <= sel_next;
            rr       <= rr_next;
            overflow <= overflow | drop;
            if (commit_acc) begin
                armed  <= 1'b1;
                wd_cnt <= '0;
            end else if (armed && TIMEOUT > 0 && wd_cnt != WW'(TIMEOUT)) begin
                wd_cnt <= wd_cnt + 1'b1;
                if (wd_cnt + 1'b1 == WW'(TIMEOUT)) hang <= 1'b1;
            end
        end
    end

endmodule
